// File: rtl/hit_resolver.sv
`default_nettype none
// ============================================================================
// Module      : hit_resolver
// Description : Damage / round controller downstream of the hit-scan block.
//               Enforces one hit per attack, applies saturating damage to the
//               two health counters, runs per-player hitstun timers and the
//               IDLE/FIGHT/KO round state machine.
//               Optional feature macro: COMBO_SCALE_EN (halves damage, min 1,
//               for hits landing on an already-stunned defender).
// Revision    : 1.0 - initial release
// ============================================================================
module hit_resolver #(
    parameter logic [6:0] MAX_HEALTH  = 7'd100,
    parameter logic [6:0] BASIC_DMG   = 7'd10,
    parameter logic [6:0] DIR_DMG     = 7'd15,
    parameter logic [5:0] STUN_FRAMES = 6'd20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       round_start,
    input  logic       hitscan1,
    input  logic       hitscan2,
    input  logic [3:0] Player1NS,
    input  logic [3:0] Player2NS,
    output logic [6:0] p1_health,
    output logic [6:0] p2_health,
    output logic       p1_stun,
    output logic       p2_stun,
    output logic       hit1_pulse,
    output logic       hit2_pulse,
    output logic [1:0] round_state,
    output logic [1:0] winner
);

    // Player next-state codes that carry a live attack box.
    localparam logic [3:0] c_NS_BASIC_ACTIVE = 4'd4;
    localparam logic [3:0] c_NS_DIR_ACTIVE   = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIGHT = 2'd1,
        S_KO    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] winner_q, winner_d;
    logic [6:0] health1_q, health1_d;
    logic [6:0] health2_q, health2_d;
    logic [5:0] stun1_q, stun1_d;
    logic [5:0] stun2_q, stun2_d;
    logic       cons1_q, cons1_d;   // P1's current attack already landed
    logic       cons2_q, cons2_d;   // P2's current attack already landed
    logic       hit1_q, hit1_d;
    logic       hit2_q, hit2_d;

    logic       atk1_active;
    logic       atk2_active;
    logic       hit_on_p1;
    logic       hit_on_p2;
    logic [6:0] raw_dmg1;
    logic [6:0] raw_dmg2;
    logic [6:0] dmg1;
    logic [6:0] dmg2;

    // Subtract damage with saturation at zero (no underflow wrap).
    function automatic logic [6:0] sat_sub(input logic [6:0] h, input logic [6:0] d);
        return (h <= d) ? 7'd0 : (h - d);
    endfunction

    // Hit qualification; a hit on a player is owned by the opponent's attack.
    always_comb begin
        atk1_active = (Player1NS == c_NS_BASIC_ACTIVE) || (Player1NS == c_NS_DIR_ACTIVE);
        atk2_active = (Player2NS == c_NS_BASIC_ACTIVE) || (Player2NS == c_NS_DIR_ACTIVE);
        hit_on_p1   = (state_q == S_FIGHT) && hitscan1 && atk2_active && !cons2_q && !round_start;
        hit_on_p2   = (state_q == S_FIGHT) && hitscan2 && atk1_active && !cons1_q && !round_start;
        raw_dmg1    = (Player2NS == c_NS_BASIC_ACTIVE) ? BASIC_DMG : DIR_DMG;
        raw_dmg2    = (Player1NS == c_NS_BASIC_ACTIVE) ? BASIC_DMG : DIR_DMG;
`ifdef COMBO_SCALE_EN
        // Combo hits on a stunned defender deal half damage, never below 1.
        dmg1 = raw_dmg1;
        dmg2 = raw_dmg2;
        if (stun1_q != 6'd0) begin
            dmg1 = ((raw_dmg1 >> 1) == 7'd0) ? 7'd1 : (raw_dmg1 >> 1);
        end
        if (stun2_q != 6'd0) begin
            dmg2 = ((raw_dmg2 >> 1) == 7'd0) ? 7'd1 : (raw_dmg2 >> 1);
        end
`else
        dmg1 = raw_dmg1;
        dmg2 = raw_dmg2;
`endif
    end

    // Round FSM next-state and winner decode; round_start always restarts.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        if (round_start) begin
            state_d  = S_FIGHT;
            winner_d = 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_FIGHT: begin
                    if ((health1_q == 7'd0) || (health2_q == 7'd0)) begin
                        state_d  = S_KO;
                        // bit1: P1 dead, bit0: P2 dead -> 1=P1 wins, 2=P2 wins, 3=draw
                        winner_d = {health1_q == 7'd0, health2_q == 7'd0};
                    end
                end
                S_KO: begin
                    state_d = S_KO;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Health, stun timers, consumed flags and hit pulses.
    always_comb begin
        health1_d = health1_q;
        health2_d = health2_q;
        stun1_d   = stun1_q;
        stun2_d   = stun2_q;
        cons1_d   = cons1_q;
        cons2_d   = cons2_q;
        hit1_d    = 1'b0;
        hit2_d    = 1'b0;
        if (round_start) begin
            health1_d = MAX_HEALTH;
            health2_d = MAX_HEALTH;
            stun1_d   = 6'd0;
            stun2_d   = 6'd0;
            cons1_d   = 1'b0;
            cons2_d   = 1'b0;
        end else begin
            // P1 as defender
            if (hit_on_p1) begin
                health1_d = sat_sub(health1_q, dmg1);
                stun1_d   = STUN_FRAMES;
                hit1_d    = 1'b1;
            end else if (frame_tick && (stun1_q != 6'd0)) begin
                stun1_d = stun1_q - 6'd1;
            end
            // P2 as defender
            if (hit_on_p2) begin
                health2_d = sat_sub(health2_q, dmg2);
                stun2_d   = STUN_FRAMES;
                hit2_d    = 1'b1;
            end else if (frame_tick && (stun2_q != 6'd0)) begin
                stun2_d = stun2_q - 6'd1;
            end
            // An attack is consumed by its first landed hit until it ends.
            if (hit_on_p1) begin
                cons2_d = 1'b1;
            end else if (!atk2_active) begin
                cons2_d = 1'b0;
            end
            if (hit_on_p2) begin
                cons1_d = 1'b1;
            end else if (!atk1_active) begin
                cons1_d = 1'b0;
            end
        end
    end

    // Round FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            winner_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            health1_q <= MAX_HEALTH;
            health2_q <= MAX_HEALTH;
            stun1_q   <= 6'd0;
            stun2_q   <= 6'd0;
            cons1_q   <= 1'b0;
            cons2_q   <= 1'b0;
            hit1_q    <= 1'b0;
            hit2_q    <= 1'b0;
        end else begin
            health1_q <= health1_d;
            health2_q <= health2_d;
            stun1_q   <= stun1_d;
            stun2_q   <= stun2_d;
            cons1_q   <= cons1_d;
            cons2_q   <= cons2_d;
            hit1_q    <= hit1_d;
            hit2_q    <= hit2_d;
        end
    end

    assign p1_health   = health1_q;
    assign p2_health   = health2_q;
    assign p1_stun     = (stun1_q != 6'd0);
    assign p2_stun     = (stun2_q != 6'd0);
    assign hit1_pulse  = hit1_q;
    assign hit2_pulse  = hit2_q;
    assign round_state = state_q;
    assign winner      = winner_q;

endmodule
`default_nettype wire
